mac_pe_pipe: RTL and testbench
==============================

Name: mac_pe_pipe

Overview:
- Parametrised, pipelined successor to the team's systolic MAC processing element.
- Forwards A/B to neighbours and accumulates A*B into a local signed accumulator over a 2-stage pipeline (multiply, then accumulate).
- Adds per-operand valid tagging, synchronous clear, a saturating/wrapping mode and a sticky overflow flag.
- Tiles into the same 2-D systolic array as the existing PE; C preload via WrEn is retained.

Parameters:
- BITS_AB, 8, signed width of A and B operands.
- BITS_C, 16, signed accumulator width; must satisfy BITS_C >= 2*BITS_AB (elaboration-time assertion).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global pipeline enable; low = every register holds.
- WrEn  input  1  preload accumulator from Cin.
- clr  input  1  synchronous clear of accumulator, pipeline valid bits and ovf.
- sat_en  input  1  1 = saturate on overflow, 0 = two's-complement wrap.
- vld_in  input  1  Ain/Bin pair is a real operand this cycle.
- Ain  input  BITS_AB  signed operand A.
- Bin  input  BITS_AB  signed operand B.
- Cin  input  BITS_C  signed preload value.
- Aout  output  BITS_AB  registered Ain, forwarded to east neighbour.
- Bout  output  BITS_AB  registered Bin, forwarded to south neighbour.
- vld_out  output  1  registered vld_in, forwarded alongside Aout/Bout.
- Cout  output  BITS_C  signed accumulator.
- acc_vld  output  1  pulses for one enabled cycle after each accumulate.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): Aout, Bout, Cout, internal product register P and stage-1 valid v1 all 0; vld_out, acc_vld and ovf all 0.
- en low: every register holds, including ovf and acc_vld. clr and WrEn are ignored.
- Stage 1, on an en cycle:
  - Aout<=Ain, Bout<=Bin, vld_out<=vld_in.
  - P<=Ain*Bin as a full 2*BITS_AB signed product; v1<=vld_in.
  - Forwarding is unaffected by clr and WrEn.
- Stage 2 priority, on an en cycle: clr > WrEn > accumulate.
  - clr: Cout<=0, ovf<=0, v1<=0, acc_vld<=0.
  - WrEn: Cout<=Cin, v1<=0 (the in-flight product is discarded), acc_vld<=0; ovf holds.
  - Accumulate when v1=1: S = sext(Cout) + sext(P) computed at BITS_C+1 bits.
    - Overflow when S[BITS_C] != S[BITS_C-1].
    - No overflow: Cout<=S[BITS_C-1:0].
    - Overflow with sat_en=1: Cout<=+2^(BITS_C-1)-1 if S is positive, else -2^(BITS_C-1).
    - Overflow with sat_en=0: Cout<=S[BITS_C-1:0] (wrap).
    - ovf<=1 on any overflow, independent of sat_en; it clears only on clr or reset.
    - acc_vld<=1.
  - v1=0 and neither clr nor WrEn: Cout holds, acc_vld<=0.
- Latency:
  - Aout/Bout/vld_out: 1 enabled cycle.
  - Operand to Cout update: 2 enabled cycles; acc_vld is asserted in the same cycle Cout shows the new value.
- Back-to-back valid operands sustain one accumulate per enabled cycle; there is no bubble.
- en low between stages stretches latency by the stalled cycles; no operand is lost or duplicated.
- Reset asserted mid-operation: all state cleared immediately; in-flight products are lost.

Test Plan (BITS_AB=8, BITS_C=16):
- Reset: drive rst_n low asynchronously mid-cycle -> Cout=0, Aout=0, Bout=0, vld_out=0, acc_vld=0, ovf=0 immediately.
- Preload and MAC: WrEn, Cin=100; next cycle vld_in=1, Ain=3, Bin=-4 -> Aout=3, Bout=-4 after 1 cycle; Cout=88 with acc_vld=1 after 2 cycles. Follow with 4 back-to-back valid pairs (5,5) -> Cout=113,138,163,188 on consecutive cycles.
- Saturation: preload 32760; Ain=127, Bin=127, sat_en=1 -> Cout=32767, ovf=1. Repeat with sat_en=0 -> Cout=-16647, ovf=1. Preload -32760 with Ain=-128, Bin=127, sat_en=1 -> Cout=-32768.
- Stall: valid (2,3) issued, then en low for 3 cycles -> Cout, Aout, acc_vld frozen. en high -> Cout increases by 6 exactly once.
- Priority: clr and WrEn high together with valid product in flight, Cin=555 -> Cout=0, ovf=0, acc_vld=0, and no later update from the discarded product. WrEn alone with product in flight -> Cout=555 and stays 555.
- Invalid data: vld_in=0 with Ain=50, Bin=50 -> Aout=50 forwarded, vld_out=0, Cout unchanged, acc_vld=0.

Source files
------------

// File: rtl/mac_pe_pipe_if.sv
// Operand/result bundle for one systolic MAC processing element.
// The master drives operands and controls; the slave (the PE) drives
// the forwarded operands and the accumulator state.
interface mac_pe_pipe_if #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16
);
   logic                      en;
   logic                      WrEn;
   logic                      clr;
   logic                      sat_en;
   logic                      vld_in;
   logic signed [BITS_AB-1:0] Ain;
   logic signed [BITS_AB-1:0] Bin;
   logic signed [BITS_C-1:0]  Cin;
   logic signed [BITS_AB-1:0] Aout;
   logic signed [BITS_AB-1:0] Bout;
   logic                      vld_out;
   logic signed [BITS_C-1:0]  Cout;
   logic                      acc_vld;
   logic                      ovf;

   modport master (
      output en, WrEn, clr, sat_en, vld_in, Ain, Bin, Cin,
      input  Aout, Bout, vld_out, Cout, acc_vld, ovf
   );

   modport slave (
      input  en, WrEn, clr, sat_en, vld_in, Ain, Bin, Cin,
      output Aout, Bout, vld_out, Cout, acc_vld, ovf
   );
endinterface

// File: rtl/mac_pe_pipe.sv
// Pipelined systolic MAC processing element.
// Stage 1 forwards A/B east/south and registers the full-width product.
// Stage 2 adds the product into a signed accumulator with optional
// saturation and a sticky overflow flag. en low freezes everything.
module mac_pe_pipe #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   mac_pe_pipe_if.slave   bus
);
   localparam int PW = 2 * BITS_AB;

   // The accumulator must hold at least one full product.
   generate
      if (BITS_C < PW) begin : g_bad_width
         $error("mac_pe_pipe: BITS_C must be >= 2*BITS_AB");
      end
   endgenerate

   localparam logic signed [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
   localparam logic signed [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

   logic signed [BITS_AB-1:0] r_a;
   logic signed [BITS_AB-1:0] r_b;
   logic                      r_vld;
   logic signed [PW-1:0]      r_p;
   logic                      r_v1;
   logic signed [BITS_C-1:0]  r_c;
   logic                      r_acc_vld;
   logic                      r_ovf;

   logic signed [PW-1:0]      w_prod;
   logic signed [BITS_C:0]    w_c_ext;
   logic signed [BITS_C:0]    w_p_ext;
   logic signed [BITS_C:0]    w_sum;
   logic                      w_of;
   logic signed [BITS_C-1:0]  w_acc;

   // Operands widened before the multiply so the product keeps every bit.
   assign w_prod  = PW'(bus.Ain) * PW'(bus.Bin);

   // One guard bit above the accumulator exposes overflow as a sign mismatch.
   assign w_c_ext = {r_c[BITS_C-1], r_c};
   assign w_p_ext = {{(BITS_C+1-PW){r_p[PW-1]}}, r_p};
   assign w_sum   = w_c_ext + w_p_ext;
   assign w_of    = w_sum[BITS_C] ^ w_sum[BITS_C-1];

   // Resolve the accumulate result: clamp toward the true sign when saturating.
   always_comb begin
      w_acc = w_sum[BITS_C-1:0];
      if (w_of && bus.sat_en)
         w_acc = w_sum[BITS_C] ? C_MIN : C_MAX;
   end

   // Stage 1: forward operands to neighbours and register the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_vld <= 1'b0;
         r_p   <= '0;
      end else if (bus.en) begin
         r_a   <= bus.Ain;
         r_b   <= bus.Bin;
         r_vld <= bus.vld_in;
         r_p   <= w_prod;
      end
   end

   // Stage 2: clear beats preload beats accumulate; clear/preload also
   // drop the product entering the pipe so it never lands later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         r_c       <= '0;
         r_acc_vld <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (bus.en) begin
         if (bus.clr) begin
            r_v1      <= 1'b0;
            r_c       <= '0;
            r_acc_vld <= 1'b0;
            r_ovf     <= 1'b0;
         end else if (bus.WrEn) begin
            r_v1      <= 1'b0;
            r_c       <= bus.Cin;
            r_acc_vld <= 1'b0;
         end else begin
            r_v1 <= bus.vld_in;
            if (r_v1) begin
               r_c       <= w_acc;
               r_acc_vld <= 1'b1;
               if (w_of)
                  r_ovf <= 1'b1;
            end else begin
               r_acc_vld <= 1'b0;
            end
         end
      end
   end

   assign bus.Aout    = r_a;
   assign bus.Bout    = r_b;
   assign bus.vld_out = r_vld;
   assign bus.Cout    = r_c;
   assign bus.acc_vld = r_acc_vld;
   assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_mac_pe_pipe.sv
// Directed bench for mac_pe_pipe (BITS_AB=8, BITS_C=16).
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_mac_pe_pipe;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mac_pe_pipe_if #(.BITS_AB(8), .BITS_C(16)) bus ();

   mac_pe_pipe #(.BITS_AB(8), .BITS_C(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic signed [7:0] a,
                      input logic signed [7:0] b);
      bus.vld_in = v;
      bus.Ain    = a;
      bus.Bin    = b;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.en = 1'b1; bus.WrEn = 1'b0; bus.clr = 1'b0; bus.sat_en = 1'b0;
      bus.Cin = '0;
      drv(1'b0, 8'sd0, 8'sd0);
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_cout", bus.Cout, 0);
      chk("rst_ovf", bus.ovf, 0);

      // Preload 100, then 3*-4 followed by four back-to-back 5*5.
      bus.WrEn = 1'b1; bus.Cin = 16'sd100;
      tick();
      chk("pre_cout", bus.Cout, 100);
      chk("pre_accvld", bus.acc_vld, 0);
      bus.WrEn = 1'b0;
      drv(1'b1, 8'sd3, -8'sd4);
      tick();
      chk("fwd_a", bus.Aout, 3);
      chk("fwd_b", bus.Bout, -4);
      chk("fwd_vld", bus.vld_out, 1);
      chk("lat1_cout", bus.Cout, 100);
      drv(1'b1, 8'sd5, 8'sd5);
      tick();
      chk("mac0_cout", bus.Cout, 88);
      chk("mac0_accvld", bus.acc_vld, 1);
      tick();
      chk("mac1_cout", bus.Cout, 113);
      tick();
      chk("mac2_cout", bus.Cout, 138);
      tick();
      chk("mac3_cout", bus.Cout, 163);
      chk("mac3_accvld", bus.acc_vld, 1);

      // Invalid operands still forward but never accumulate.
      drv(1'b0, 8'sd50, 8'sd50);
      tick();
      chk("mac4_cout", bus.Cout, 188);
      chk("inv_a", bus.Aout, 50);
      chk("inv_vld", bus.vld_out, 0);
      tick();
      chk("inv_cout", bus.Cout, 188);
      chk("inv_accvld", bus.acc_vld, 0);

      // Asynchronous reset mid-cycle with a product in flight.
      drv(1'b1, 8'sd3, 8'sd3);
      tick();
      drv(1'b0, 8'sd0, 8'sd0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_cout", bus.Cout, 0);
      chk("arst_a", bus.Aout, 0);
      chk("arst_b", bus.Bout, 0);
      chk("arst_vld", bus.vld_out, 0);
      chk("arst_accvld", bus.acc_vld, 0);
      chk("arst_ovf", bus.ovf, 0);
      #1 rst_n = 1'b1;
      tick();
      chk("arst_lost_cout", bus.Cout, 0);
      chk("arst_lost_accvld", bus.acc_vld, 0);

      // Positive saturation: 32760 + 16129.
      bus.sat_en = 1'b1; bus.WrEn = 1'b1; bus.Cin = 16'sd32760;
      tick();
      bus.WrEn = 1'b0;
      drv(1'b1, 8'sd127, 8'sd127);
      tick();
      drv(1'b0, 8'sd0, 8'sd0);
      tick();
      chk("satp_cout", bus.Cout, 32767);
      chk("satp_ovf", bus.ovf, 1);

      // Same sum wrapping; ovf stays sticky across the preload.
      bus.sat_en = 1'b0; bus.WrEn = 1'b1; bus.Cin = 16'sd32760;
      tick();
      chk("sticky_ovf", bus.ovf, 1);
      bus.WrEn = 1'b0;
      drv(1'b1, 8'sd127, 8'sd127);
      tick();
      drv(1'b0, 8'sd0, 8'sd0);
      tick();
      chk("wrap_cout", bus.Cout, -16647);
      chk("wrap_ovf", bus.ovf, 1);
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("clr_cout", bus.Cout, 0);
      chk("clr_ovf", bus.ovf, 0);

      // Negative saturation: -32760 + -16256.
      bus.sat_en = 1'b1; bus.WrEn = 1'b1; bus.Cin = -16'sd32760;
      tick();
      bus.WrEn = 1'b0;
      drv(1'b1, -8'sd128, 8'sd127);
      tick();
      drv(1'b0, 8'sd0, 8'sd0);
      tick();
      chk("satn_cout", bus.Cout, -32768);
      chk("satn_ovf", bus.ovf, 1);

      // Stall between stages; clr/WrEn and new operands ignored while en low.
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0; bus.WrEn = 1'b1; bus.Cin = 16'sd10;
      tick();
      bus.WrEn = 1'b0;
      drv(1'b1, 8'sd2, 8'sd3);
      tick();
      bus.en = 1'b0; bus.clr = 1'b1; bus.WrEn = 1'b1; bus.Cin = 16'sd999;
      drv(1'b1, 8'sd9, 8'sd9);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_cout", bus.Cout, 10);
         chk("stall_a", bus.Aout, 2);
         chk("stall_accvld", bus.acc_vld, 0);
      end
      bus.en = 1'b1; bus.clr = 1'b0; bus.WrEn = 1'b0;
      drv(1'b0, 8'sd0, 8'sd0);
      tick();
      chk("unstall_cout", bus.Cout, 16);
      chk("unstall_accvld", bus.acc_vld, 1);
      bus.en = 1'b0;
      tick();
      chk("hold_accvld", bus.acc_vld, 1);
      chk("hold_cout", bus.Cout, 16);
      bus.en = 1'b1;
      tick();
      chk("once_cout", bus.Cout, 16);
      chk("once_accvld", bus.acc_vld, 0);

      // clr beats WrEn; in-flight product discarded.
      drv(1'b1, 8'sd4, 8'sd4);
      tick();
      drv(1'b0, 8'sd0, 8'sd0);
      bus.clr = 1'b1; bus.WrEn = 1'b1; bus.Cin = 16'sd555;
      tick();
      bus.clr = 1'b0; bus.WrEn = 1'b0;
      chk("prio_cout", bus.Cout, 0);
      chk("prio_ovf", bus.ovf, 0);
      chk("prio_accvld", bus.acc_vld, 0);
      tick();
      chk("prio_late_cout", bus.Cout, 0);
      chk("prio_late_accvld", bus.acc_vld, 0);

      // WrEn alone discards the in-flight product.
      drv(1'b1, 8'sd4, 8'sd4);
      tick();
      drv(1'b0, 8'sd0, 8'sd0);
      bus.WrEn = 1'b1;
      tick();
      bus.WrEn = 1'b0;
      chk("wr_cout", bus.Cout, 555);
      tick();
      chk("wr_late_cout", bus.Cout, 555);
      chk("wr_late_accvld", bus.acc_vld, 0);
      tick();
      chk("wr_late2_cout", bus.Cout, 555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
